// File: rtl/bf16_lane_packer_if.sv
// bf16_lane_packer_if: FP32 input stream and packed-BF16 output stream of the lane packer.
interface bf16_lane_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_lane_mask;
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_lane_mask
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_lane_mask
  );
endinterface

// File: rtl/bf16_lane_packer.sv
// bf16_lane_packer: FP32 to BF16 (RNE) narrowing, pairing results into {hi, lo} packed words.
module bf16_lane_packer #(
  parameter logic [15:0] PAD = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  bf16_lane_packer_if.slave          s,
  output logic [15:0]                words_out
);
  typedef enum logic {EMPTY, HALF} state_t;
  state_t      state_q, state_d;
  logic [15:0] hi_q, hi_d;
  logic [31:0] out_data_q, out_data_d;
  logic [1:0]  out_mask_q, out_mask_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] words_q, words_d;
  logic [15:0] conv;
  logic        rnd, acc, xfer, emit;
  always_comb begin
    rnd  = s.in_data[15] && (|s.in_data[14:0] || s.in_data[16]);
    conv = (s.in_data[30:23] == 8'hFF) ? ((|s.in_data[22:0]) ? {s.in_data[31], 15'h7FC0} : s.in_data[31:16])
         : (s.in_data[30:23] == 8'h00) ? {s.in_data[31], 15'h0000}
         : s.in_data[31:16] + {15'd0, rnd};
  end
  assign s.in_ready = !out_valid_q || s.out_ready;
  // emit takes priority over the transfer-driven clear, giving bubble-free back-to-back words
  always_comb begin
    acc         = s.in_valid && s.in_ready;
    xfer        = out_valid_q && s.out_ready;
    emit        = acc && (state_q == HALF || s.in_last);
    state_d     = acc ? ((state_q == EMPTY && !s.in_last) ? HALF : EMPTY) : state_q;
    hi_d        = (acc && state_q == EMPTY && !s.in_last) ? conv : hi_q;
    out_data_d  = emit ? ((state_q == HALF) ? {hi_q, conv} : {conv, PAD}) : out_data_q;
    out_mask_d  = emit ? ((state_q == HALF) ? 2'b11 : 2'b10) : out_mask_q;
    out_valid_d = emit || (out_valid_q && !s.out_ready);
    words_d     = words_q + {15'd0, xfer};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      hi_q        <= '0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_valid_q <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_valid_q <= out_valid_d;
      words_q     <= words_d;
    end
  end
  assign s.out_valid     = out_valid_q;
  assign s.out_data      = out_data_q;
  assign s.out_lane_mask = out_mask_q;
  assign words_out       = words_q;
endmodule
